// File: rtl/tinyriscv_pkg.sv
// Shared bus types and interrupt-controller register map for the tinyriscv core.
package tinyriscv_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
   typedef logic [MEM_DATA_W-1:0] mem_bus_t;

   // Word indices (byte offset >> 2) of the irq_ctrl registers.
   localparam logic [2:0] IRQ_PENDING   = 3'd0;
   localparam logic [2:0] IRQ_ENABLE    = 3'd1;
   localparam logic [2:0] IRQ_MODE      = 3'd2;
   localparam logic [2:0] IRQ_CLAIM     = 3'd3;
   localparam logic [2:0] IRQ_INSERVICE = 3'd4;

   typedef enum logic {IRQ_IDLE, IRQ_RESP} irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchroniser chain plus a one-flop history for rising-edge detection.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic s_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic                   hist_q;

   // Zeroing the history too means a line already high at reset release reads as one edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chain_q <= '0;
         hist_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
         hist_q  <= chain_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = chain_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~hist_q;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with pending/enable/mode/claim/in-service registers.
// Bus handshake: an access is taken when req_i is seen in IDLE; ready_o then pulses for one cycle.
module irq_ctrl import tinyriscv_pkg::*; #(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             we_i,
   input  mem_addr_t        addr_i,
   input  mem_bus_t         data_i,
   output mem_bus_t         data_o,
   output logic             ready_o,
   input  logic [N_SRC-1:0] src_i,
   output logic             irq_o
);

   logic [N_SRC-1:0] s, rise, active;
   logic [N_SRC-1:0] pending_q, pending_d, enable_q, enable_d;
   logic [N_SRC-1:0] mode_q, mode_d, in_service_q, in_service_d;
   irq_state_e       state_q;
   mem_bus_t         data_q, rdata;
   logic             ready_q, irq_q;
   logic             access, wr, rd, claim_hit, complete_ok;
   logic [2:0]       word;
   logic [4:0]       claim_val, complete_val;
   logic             unused_addr;

   function automatic logic [4:0] prio_claim(input logic [N_SRC-1:0] v);
      logic [4:0] r;
      r = 5'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) r = 5'(i + 1);
      end
      return r;
   endfunction

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .d_i    (src_i[g]),
         .s_o    (s[g]),
         .rise_o (rise[g])
      );
   end

   assign access       = req_i && (state_q == IRQ_IDLE);
   assign wr           = access && we_i;
   assign rd           = access && !we_i;
   assign word         = addr_i[4:2];
   assign active       = pending_q & enable_q & ~in_service_q;
   assign claim_val    = prio_claim(active);
   assign claim_hit    = rd && (word == IRQ_CLAIM) && (claim_val != 5'd0);
   assign complete_ok  = wr && (word == IRQ_CLAIM) && (data_i != '0) && (data_i <= mem_bus_t'(N_SRC));
   assign complete_val = data_i[4:0];
   assign unused_addr  = ^{addr_i[MEM_ADDR_W-1:5], addr_i[1:0]};

   always_comb begin
      enable_d     = enable_q;
      mode_d       = mode_q;
      pending_d    = pending_q;
      in_service_d = in_service_q;
      if (wr && word == IRQ_ENABLE) enable_d = data_i[N_SRC-1:0];
      if (wr && word == IRQ_MODE)   mode_d   = data_i[N_SRC-1:0];
      for (int i = 0; i < N_SRC; i++) begin
         // Edge sources: clears first, then a fresh edge wins.
         if (mode_q[i]) begin
            if (wr && word == IRQ_PENDING && data_i[i]) pending_d[i] = 1'b0;
            if (claim_hit && claim_val == 5'(i + 1))     pending_d[i] = 1'b0;
            if (rise[i])                                 pending_d[i] = 1'b1;
         end else begin
            pending_d[i] = s[i];
         end
         if (claim_hit && claim_val == 5'(i + 1))      in_service_d[i] = 1'b1;
         if (complete_ok && complete_val == 5'(i + 1)) in_service_d[i] = 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (word)
         IRQ_PENDING:   rdata = mem_bus_t'(pending_q);
         IRQ_ENABLE:    rdata = mem_bus_t'(enable_q);
         IRQ_MODE:      rdata = mem_bus_t'(mode_q);
         IRQ_CLAIM:     rdata = mem_bus_t'(claim_val);
         IRQ_INSERVICE: rdata = mem_bus_t'(in_service_q);
         default:       rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q    <= '0;
         enable_q     <= '0;
         mode_q       <= '0;
         in_service_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         mode_q       <= mode_d;
         in_service_q <= in_service_d;
         irq_q        <= |active;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IRQ_IDLE;
         data_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IRQ_IDLE: begin
               if (req_i) begin
                  state_q <= IRQ_RESP;
                  ready_q <= 1'b1;
                  data_q  <= we_i ? '0 : rdata;
               end
            end
            IRQ_RESP: begin
               state_q <= IRQ_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_o  = data_q;
   assign ready_o = ready_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_irq_ctrl;

   localparam int N_SRC = 8;
   localparam int SYNC  = 2;
   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam logic [31:0] A_PEND  = BASE + 32'h00;
   localparam logic [31:0] A_EN    = BASE + 32'h04;
   localparam logic [31:0] A_MODE  = BASE + 32'h08;
   localparam logic [31:0] A_CLAIM = BASE + 32'h0C;
   localparam logic [31:0] A_INSV  = BASE + 32'h10;
   localparam logic [31:0] A_BAD   = BASE + 32'h14;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             req_i = 1'b0;
   logic             we_i = 1'b0;
   logic [31:0]      addr_i = '0;
   logic [31:0]      data_i = '0;
   logic [31:0]      data_o;
   logic             ready_o;
   logic [N_SRC-1:0] src_i = '0;
   logic             irq_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   irq_ctrl #(.N_SRC(N_SRC), .SYNC_STAGES(SYNC)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .ready_o (ready_o),
      .src_i   (src_i),
      .irq_o   (irq_o)
   );

   // Reference model: src delay line as a queue of past samples, registers as plain vectors.
   logic [N_SRC-1:0] m_pend, m_en, m_mode, m_insv;
   logic             m_irq, m_ready, m_busy, m_rd;
   logic [31:0]      m_data;
   logic [N_SRC-1:0] hist[$];
   logic [N_SRC-1:0] mm_s, mm_sd, mm_cand, mm_np, mm_ni, mm_ne, mm_nm;
   logic             mm_acc, mm_clr;
   int               mm_cl, mm_k;
   logic [2:0]       mm_word;

   always @(posedge clk) begin
      if (rst_i) begin
         m_pend = '0; m_en = '0; m_mode = '0; m_insv = '0;
         m_irq = 1'b0; m_ready = 1'b0; m_busy = 1'b0; m_rd = 1'b0; m_data = '0;
         hist = {};
         repeat (SYNC + 1) hist.push_front('0);
      end else begin
         mm_s = hist[SYNC-1];
         mm_sd = hist[SYNC];
         mm_cand = m_pend & m_en & ~m_insv;
         mm_cl = 0;
         for (int i = N_SRC - 1; i >= 0; i--) if (mm_cand[i]) mm_cl = i + 1;
         mm_acc = req_i && !m_busy;
         mm_word = addr_i[4:2];
         mm_np = m_pend; mm_ni = m_insv; mm_ne = m_en; mm_nm = m_mode;
         for (int i = 0; i < N_SRC; i++) begin
            if (!m_mode[i]) mm_np[i] = mm_s[i];
            else begin
               mm_clr = (mm_acc && we_i && mm_word == 3'd0 && data_i[i]) ||
                        (mm_acc && !we_i && mm_word == 3'd3 && mm_cl == i + 1);
               mm_np[i] = (m_pend[i] && !mm_clr) || (mm_s[i] && !mm_sd[i]);
            end
         end
         if (mm_acc && !we_i) begin
            case (mm_word)
               3'd0: m_data = 32'(m_pend);
               3'd1: m_data = 32'(m_en);
               3'd2: m_data = 32'(m_mode);
               3'd3: m_data = 32'(mm_cl);
               3'd4: m_data = 32'(m_insv);
               default: m_data = '0;
            endcase
            if (mm_word == 3'd3 && mm_cl != 0) mm_ni[mm_cl-1] = 1'b1;
         end
         if (mm_acc && we_i) begin
            if (mm_word == 3'd1) mm_ne = data_i[N_SRC-1:0];
            if (mm_word == 3'd2) mm_nm = data_i[N_SRC-1:0];
            mm_k = int'(data_i);
            if (mm_word == 3'd3 && data_i >= 1 && data_i <= N_SRC && m_insv[mm_k-1]) mm_ni[mm_k-1] = 1'b0;
         end
         m_irq = |mm_cand;
         m_pend = mm_np; m_insv = mm_ni; m_en = mm_ne; m_mode = mm_nm;
         m_ready = mm_acc;
         m_busy = mm_acc;
         if (mm_acc) m_rd = !we_i;
         void'(hist.pop_back());
         hist.push_front(src_i);
      end
   end

   task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
      int waited;
      waited = 0;
      @(negedge clk);
      req_i = 1'b1; we_i = we; addr_i = addr; data_i = wdata;
      @(negedge clk);
      while (ready_o !== 1'b1 && waited < 4) begin
         @(negedge clk);
         waited++;
      end
      n_vec++;
      if (ready_o !== 1'b1) begin
         $display("FAIL bus_ready: ready_o=%b want 1 (addr %h)", ready_o, addr);
         n_err++;
      end
      rdata = data_o;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      bus(1'b1, addr, wdata, dummy);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (data_o !== 32'h0) begin $display("FAIL rst_data: got %h want 0", data_o); n_err++; end
      n_vec++; if (ready_o !== 1'b0) begin $display("FAIL rst_ready: got %b want 0", ready_o); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL rst_irq: got %b want 0", irq_o); n_err++; end
      rst_i = 1'b0;
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rst_pend: got %h want 0", rd); n_err++; end
      bus(1'b0, A_EN, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rst_en: got %h want 0", rd); n_err++; end
      bus(1'b0, A_MODE, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rst_mode: got %h want 0", rd); n_err++; end
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rst_claim: got %h want 0", rd); n_err++; end
   endtask

   task automatic test_edge_claim();
      logic [31:0] rd;
      wr(A_EN, 32'h01);
      wr(A_MODE, 32'h01);
      src_i[0] = 1'b1;
      @(negedge clk);
      src_i[0] = 1'b0;
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL edge_pend_early: got %h want 0", rd); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL edge_irq_early: got %b want 0", irq_o); n_err++; end
      @(negedge clk);
      n_vec++; if (irq_o !== 1'b1) begin $display("FAIL edge_irq_4: got %b want 1", irq_o); n_err++; end
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h1) begin $display("FAIL edge_pend: got %h want 1", rd); n_err++; end
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'h1) begin $display("FAIL edge_claim: got %h want 1", rd); n_err++; end
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h1) begin $display("FAIL edge_insv: got %h want 1", rd); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL edge_irq_claimed: got %b want 0", irq_o); n_err++; end
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL edge_pend_claimed: got %h want 0", rd); n_err++; end
      wr(A_CLAIM, 32'd1);
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL edge_complete: got %h want 0", rd); n_err++; end
   endtask

   task automatic test_priority();
      logic [31:0] rd;
      wr(A_EN, 32'h0A);
      wr(A_MODE, 32'h0A);
      src_i[1] = 1'b1; src_i[3] = 1'b1;
      @(negedge clk);
      src_i[1] = 1'b0; src_i[3] = 1'b0;
      repeat (4) @(negedge clk);
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'd2) begin $display("FAIL prio_first: got %0d want 2", rd); n_err++; end
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'd4) begin $display("FAIL prio_second: got %0d want 4", rd); n_err++; end
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'd0) begin $display("FAIL prio_third: got %0d want 0", rd); n_err++; end
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h0A) begin $display("FAIL prio_insv: got %h want 0a", rd); n_err++; end
      wr(A_CLAIM, 32'd2);
      wr(A_CLAIM, 32'd4);
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL prio_insv_done: got %h want 0", rd); n_err++; end
   endtask

   task automatic test_level();
      logic [31:0] rd;
      wr(A_EN, 32'h04);
      wr(A_MODE, 32'h00);
      src_i[2] = 1'b1;
      repeat (4) @(negedge clk);
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'd3) begin $display("FAIL lvl_claim: got %0d want 3", rd); n_err++; end
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h04) begin $display("FAIL lvl_pend_kept: got %h want 04", rd); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL lvl_irq_claimed: got %b want 0", irq_o); n_err++; end
      wr(A_CLAIM, 32'd3);
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL lvl_irq_t1: got %b want 0", irq_o); n_err++; end
      @(negedge clk);
      n_vec++; if (irq_o !== 1'b1) begin $display("FAIL lvl_irq_t2: got %b want 1", irq_o); n_err++; end
      src_i[2] = 1'b0;
      repeat (3) @(negedge clk);
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL lvl_pend_drop: got %h want 0", rd); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL lvl_irq_drop: got %b want 0", irq_o); n_err++; end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] rd;
      wr(A_EN, 32'h01);
      wr(A_MODE, 32'h01);
      src_i[0] = 1'b1;
      @(negedge clk);
      src_i[0] = 1'b0;
      repeat (3) @(negedge clk);
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h01) begin $display("FAIL w1c_pend_set: got %h want 01", rd); n_err++; end
      wr(A_PEND, 32'h01);
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL w1c_clear: got %h want 0", rd); n_err++; end
      src_i[0] = 1'b1;
      @(negedge clk);
      src_i[0] = 1'b0;
      wr(A_PEND, 32'h01);
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h01) begin $display("FAIL w1c_collide: got %h want 01", rd); n_err++; end
      wr(A_CLAIM, 32'd7);
      wr(A_CLAIM, 32'd0);
      wr(A_CLAIM, 32'd9);
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL w1c_bad_complete: got %h want 0", rd); n_err++; end
      n_vec++; if (irq_o !== 1'b1) begin $display("FAIL w1c_irq: got %b want 1", irq_o); n_err++; end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        rdy[4];
      logic [31:0] dat[4];
      wr(A_EN, 32'h03);
      wr(A_MODE, 32'h03);
      src_i[1] = 1'b1;
      @(negedge clk);
      src_i[1] = 1'b0;
      repeat (3) @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; addr_i = A_CLAIM;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rdy[k] = ready_o;
         dat[k] = data_o;
      end
      req_i = 1'b0;
      n_vec++; if (rdy[0] !== 1'b1) begin $display("FAIL b2b_rdy1: got %b want 1", rdy[0]); n_err++; end
      n_vec++; if (rdy[1] !== 1'b0) begin $display("FAIL b2b_rdy2: got %b want 0", rdy[1]); n_err++; end
      n_vec++; if (rdy[2] !== 1'b1) begin $display("FAIL b2b_rdy3: got %b want 1", rdy[2]); n_err++; end
      n_vec++; if (rdy[3] !== 1'b0) begin $display("FAIL b2b_rdy4: got %b want 0", rdy[3]); n_err++; end
      n_vec++; if (dat[0] !== 32'd1) begin $display("FAIL b2b_claim1: got %0d want 1", dat[0]); n_err++; end
      n_vec++; if (dat[2] !== 32'd2) begin $display("FAIL b2b_claim2: got %0d want 2", dat[2]); n_err++; end
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h03) begin $display("FAIL b2b_insv: got %h want 03", rd); n_err++; end
      bus(1'b0, A_BAD, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL b2b_unmapped: got %h want 0", rd); n_err++; end
      wr(A_CLAIM, 32'd1);
      wr(A_CLAIM, 32'd2);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      wr(A_EN, 32'h05);
      wr(A_MODE, 32'h05);
      src_i[0] = 1'b1; src_i[2] = 1'b1;
      @(negedge clk);
      src_i[0] = 1'b0; src_i[2] = 1'b0;
      repeat (3) @(negedge clk);
      bus(1'b0, A_CLAIM, 0, rd);
      n_vec++; if (rd !== 32'd1) begin $display("FAIL rmid_claim: got %0d want 1", rd); n_err++; end
      repeat (2) @(negedge clk);
      n_vec++; if (irq_o !== 1'b1) begin $display("FAIL rmid_irq_pre: got %b want 1", irq_o); n_err++; end
      req_i = 1'b1; we_i = 1'b0; addr_i = A_PEND;
      @(negedge clk);
      rst_i = 1'b1; req_i = 1'b0; src_i[3] = 1'b1;
      @(negedge clk);
      n_vec++; if (data_o !== 32'h0) begin $display("FAIL rmid_data: got %h want 0", data_o); n_err++; end
      n_vec++; if (ready_o !== 1'b0) begin $display("FAIL rmid_ready: got %b want 0", ready_o); n_err++; end
      n_vec++; if (irq_o !== 1'b0) begin $display("FAIL rmid_irq: got %b want 0", irq_o); n_err++; end
      @(negedge clk);
      rst_i = 1'b0;
      wr(A_MODE, 32'h08);
      bus(1'b0, A_EN, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rmid_en: got %h want 0", rd); n_err++; end
      bus(1'b0, A_INSV, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rmid_insv: got %h want 0", rd); n_err++; end
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h08) begin $display("FAIL rmid_edge: got %h want 08", rd); n_err++; end
      wr(A_PEND, 32'h08);
      repeat (3) @(negedge clk);
      bus(1'b0, A_PEND, 0, rd);
      n_vec++; if (rd !== 32'h0) begin $display("FAIL rmid_one_edge: got %h want 0", rd); n_err++; end
      src_i[3] = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0] w;
      for (int it = 0; it < 500; it++) begin
         @(negedge clk);
         n_vec++; if (ready_o !== m_ready) begin $display("FAIL rnd_ready[%0d]: got %b want %b", it, ready_o, m_ready); n_err++; end
         if (m_ready && m_rd) begin
            n_vec++; if (data_o !== m_data) begin $display("FAIL rnd_data[%0d]: got %h want %h", it, data_o, m_data); n_err++; end
         end
         n_vec++; if (irq_o !== m_irq) begin $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq_o, m_irq); n_err++; end
         if ($urandom_range(0, 5) == 0) src_i[$urandom_range(0, N_SRC - 1)] ^= 1'b1;
         req_i = ($urandom_range(0, 2) == 0);
         we_i = ($urandom_range(0, 2) == 0);
         w = 3'($urandom_range(0, 5));
         addr_i = BASE + {27'd0, w, 2'b00};
         if (w == 3'd3) data_i = $urandom_range(0, N_SRC + 2);
         else data_i = 32'($urandom_range(0, 255));
      end
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_edge_claim();
      test_priority();
      test_level();
      test_w1c_collision();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
